// File: rtl/vcap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vcap_pkg : shared types and constants for the video capture RAM path |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vcap_pkg;

    localparam int PIX_W      = 12;
    localparam int MEM_W      = 16;
    localparam int FIFO_DEPTH = 512;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_CMD     = 3'd2,
        ST_DATA    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_REL     = 3'd5,
        ST_WAITCLR = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vcap_line_wr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vcap_mem_if : RAM controller write command / write data handshake    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface vcap_mem_if
    import vcap_pkg::*;
#(
    parameter int ADDR_W = 22
) ();
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_addr;
    logic [8:0]        cmd_len;
    logic              cmd_ready;
    logic              wr_valid;
    logic [MEM_W-1:0]  wr_data;
    logic              wr_ready;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/vcap_line_wr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vcap_line_wr : drains one captured line from the FIFO into RAM bursts |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vcap_line_wr
    import vcap_pkg::*;
#(
    parameter int                SCR_SIZE_BIT = 10,
    parameter int                ADDR_W       = 22,
    parameter int                BURST_LEN    = 64,
    parameter int                LINE_SHIFT   = 10,
    parameter logic [ADDR_W-1:0] FRAME_BASE0  = 22'h000000,
    parameter logic [ADDR_W-1:0] FRAME_BASE1  = 22'h080000
) (
    input  wire                    i_ram_clk,
    input  wire                    i_reset_n,
    input  wire                    i_enable,
    input  wire                    i_fifo_active,
    input  wire  [8:0]             i_fifo_line,
    input  wire  [PIX_W-1:0]       i_fifo_data,
    output logic                   o_fifo_next,
    output logic                   o_fifo_reset,
    input  wire  [SCR_SIZE_BIT:0]  i_x_size,
    input  wire  [SCR_SIZE_BIT:0]  i_y_size,
    vcap_mem_if.master             mem,
    output logic                   o_frame_sel,
    output logic                   o_frame_done,
    output logic                   o_busy
);

    function automatic logic [8:0] burst_len(input logic [9:0] rem);
        if (rem > 10'(BURST_LEN)) return 9'(BURST_LEN);
        else                      return rem[8:0];
    endfunction

    state_t            state_q, state_d;
    logic [8:0]        line_q,  line_d;
    logic [9:0]        rem_q,   rem_d;
    logic [8:0]        off_q,   off_d;
    logic [8:0]        burst_q, burst_d;
    logic              sel_q,   sel_d;

    logic              cmd_valid, wr_valid;
    logic [ADDR_W-1:0] cmd_addr, base;
    logic [8:0]        cmd_len;
    logic [MEM_W-1:0]  wr_data;
    logic              unused_ok;

    assign unused_ok = &{1'b0, i_x_size[SCR_SIZE_BIT:9], i_y_size[SCR_SIZE_BIT:9]};
    assign base      = sel_q ? FRAME_BASE1 : FRAME_BASE0;

    always_ff @(posedge i_ram_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            rem_q   <= '0;
            off_q   <= '0;
            burst_q <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            rem_q   <= rem_d;
            off_q   <= off_d;
            burst_q <= burst_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        rem_d        = rem_q;
        off_d        = off_q;
        burst_d      = burst_q;
        sel_d        = sel_q;
        cmd_valid    = 1'b0;
        cmd_addr     = '0;
        cmd_len      = '0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        o_fifo_next  = 1'b0;
        o_fifo_reset = 1'b0;
        o_frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_fifo_active) state_d = ST_START;
            end
            ST_START: begin
                line_d  = i_fifo_line;
                rem_d   = {1'b0, i_x_size[8:0]} + 10'd1;
                off_d   = '0;
                state_d = i_enable ? ST_CMD : ST_DRAIN;
            end
            ST_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = base + ({{(ADDR_W-9){1'b0}}, line_q} << LINE_SHIFT)
                                 + {{(ADDR_W-9){1'b0}}, off_q};
                cmd_len   = burst_len(rem_q);
                // Offset advances on acceptance; the address is only visible in CMD.
                if (mem.cmd_ready) begin
                    burst_d = cmd_len;
                    off_d   = off_q + cmd_len;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                wr_valid    = 1'b1;
                wr_data     = {{(MEM_W-PIX_W){1'b0}}, i_fifo_data};
                o_fifo_next = mem.wr_ready;
                if (mem.wr_ready) begin
                    burst_d = burst_q - 9'd1;
                    rem_d   = rem_q - 10'd1;
                    if (burst_q == 9'd1) state_d = (rem_q == 10'd1) ? ST_REL : ST_CMD;
                end
            end
            ST_DRAIN: begin
                o_fifo_next = 1'b1;
                rem_d       = rem_q - 10'd1;
                if (rem_q == 10'd1) state_d = ST_REL;
            end
            ST_REL: begin
                o_fifo_reset = 1'b1;
                if (line_q == i_y_size[8:0]) begin
                    o_frame_done = 1'b1;
                    sel_d        = ~sel_q;
                end
                state_d = ST_WAITCLR;
            end
            ST_WAITCLR: begin
                if (!i_fifo_active) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem.cmd_valid = cmd_valid;
    assign mem.cmd_addr  = cmd_addr;
    assign mem.cmd_len   = cmd_len;
    assign mem.wr_valid  = wr_valid;
    assign mem.wr_data   = wr_data;
    assign o_frame_sel   = sel_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
